// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags and error pulses.
// Latency: FWFT=0 read_data valid one cycle after accepting edge; FWFT=1 head word visible right after the write edge.
// Backpressure: writes rejected while full, reads rejected while empty; each rejection raises a one-cycle pulse.
module param_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_en,
  input  logic [DATA_W-1:0]          write_data,
  output logic                       full,
  output logic                       A_full,
  input  logic                       read_en,
  output logic [DATA_W-1:0]          read_data,
  output logic                       empty,
  output logic                       A_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     count_q;
  logic              wr_acc;
  logic              rd_acc;

  // Flags come only from the count register, so no input reaches a flag combinationally
  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign A_full  = (count_q >= AF_C);
  assign A_empty = (count_q <= AE_C);
  assign count   = count_q;

  // A request is accepted only against the registered state at this edge
  assign wr_acc = write_en && !full;
  assign rd_acc = read_en && !empty;

  // Storage array; contents survive reset, but no write lands while reset is held
  always_ff @(posedge clk) begin
    if (reset && wr_acc) begin
      mem[wptr] <= write_data;
    end
  end

  // Pointers, occupancy and error pulses; pointers wrap naturally at DEPTH-1
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= write_en && full;
      underflow <= read_en && empty;
      if (wr_acc) wptr <= wptr + AW'(1);
      if (rd_acc) rptr <= rptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown directly; forced to zero so an empty FIFO never exposes stale data
      assign read_data = empty ? '0 : mem[rptr];
    end else begin : g_reg
      logic [DATA_W-1:0] rd_q;

      // Output register loads only on an accepted read and holds otherwise
      always_ff @(posedge clk) begin
        if (!reset) begin
          rd_q <= '0;
        end else if (rd_acc) begin
          rd_q <= mem[rptr];
        end
      end

      assign read_data = rd_q;
    end
  endgenerate

endmodule

// File: doc/param_fifo.md
# param_fifo

Parametrised synchronous FIFO for the DRAM cache datapath: request, fill and writeback queues between the cache controller and the DRAM interface. It is the successor to the fixed 8-bit FIFO. It adds configurable width and depth, programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses, and a selectable first-word-fall-through read mode. Single clock domain.

## Interface
- DATA_W, 8, entry width in bits
- DEPTH, 16, number of entries; power of two, ≥ 2
- AF_LEVEL, DEPTH-2, A_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH
- AE_LEVEL, 2, A_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- write_en  in  1  push request
- write_data  in  DATA_W  push data
- full  out  1  count == DEPTH
- A_full  out  1  count ≥ AF_LEVEL
- read_en  in  1  pop request
- read_data  out  DATA_W  pop data (timing per FWFT)
- empty  out  1  count == 0
- A_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: a write was rejected
- underflow  out  1  one-cycle pulse: a read was rejected

## Operation
- Storage: DEPTH×DATA_W array, plus write pointer wptr and read pointer rptr, each $clog2(DEPTH) bits.
- Pointers wrap from DEPTH-1 to 0 by natural overflow. Occupancy is tracked in the count register, not derived from the pointers.
- Accepted write = write_en && !full: stores write_data at mem[wptr] and increments wptr.
- Accepted read = read_en && !empty: increments rptr.
- full and empty are the registered-state values at the edge.
- count update on an edge:
  - +1 on write only
  - −1 on read only
  - unchanged on both or neither
- Simultaneous write and read:
  - When the FIFO is neither full nor empty, both are accepted and count is unchanged.
  - When full, the write is rejected even if a read is accepted. overflow pulses and count drops by 1.
  - When empty, the read is rejected even if a write is accepted. underflow pulses and count rises by 1.
- overflow and underflow are registered: high for exactly one cycle after the edge where the rejected request was sampled. They are not sticky.
- FWFT=0: read_data is a register loaded with mem[rptr] on an accepted read. It holds its value at all other times, including rejected reads.
- FWFT=1: read_data = mem[rptr] combinationally whenever empty==0, and is 0 when empty. The head word is visible before read_en; read_en consumes it.
- Flags full, empty, A_full, A_empty are decoded combinationally from the count register only. No input-to-flag combinational paths.
- reset (low) has priority over any write or read in the same cycle. Reset values:
  - count = 0, wptr = rptr = 0
  - full = 0, empty = 1, A_empty = 1, A_full = 0
  - read_data = 0, overflow = underflow = 0
- Memory contents are not reset. Reset mid-operation discards all entries.

## Timing
- Write-to-visibility:
  - FWFT=1: data written at edge N appears on read_data after edge N (count = 1, empty = 0).
  - FWFT=0: the first read_en can be accepted at edge N+1; read_data is valid after that edge.
- Read latency (FWFT=0): one cycle from the accepting edge.
- Flags and count reflect all accepts at edge N immediately after edge N.
- Producers must sample full, and consumers empty, in the same cycle they assert write_en or read_en.
- Throughput: one write and one read per cycle sustained.

## Test plan
- DEPTH=4, DATA_W=8, FWFT=0: reset low for 2 cycles -> count=0, empty=1, A_empty=1, full=0, read_data=0. Write 0x11,0x22,0x33,0x44 -> full=1, count=4. Read four times -> read_data sequence 0x11..0x44, each one cycle after its read edge; empty=1 at the end.
- Full FIFO (DEPTH=4), write_en=1 with write_data=0x55 and read_en=0 -> overflow high for exactly 1 cycle, count stays 4. Subsequent reads return 0x11..0x44 (0x55 is never stored).
- Empty FIFO, read_en=1 -> underflow 1-cycle pulse, read_data holds its previous value, count=0. Empty with write and read in the same cycle -> write accepted, underflow pulses, count=1.
- Half-full FIFO, simultaneous write/read for 10 cycles with an incrementing pattern -> count constant, data out in order; pointers wrap at 3→0 with no corruption.
- AF_LEVEL=3, AE_LEVEL=1: count 0..4 -> A_empty asserted at count 0 and 1; A_full asserted at count 3 and 4; both deasserted at count 2.
- FWFT=1: write 0xA5 -> read_data=0xA5 after the same edge, before any read_en. Assert reset low with 3 entries present -> after the edge, empty=1, count=0, read_data=0.
